// File: rtl/ic_fill_ctrl_if.sv
// Signal bundle joining the fetch cache, the miss-fill sequencer
// and the shared memory arbiter.
interface ic_fill_ctrl_if;
    logic         ic_miss;
    logic [14:0]  ic_miss_addr;
    logic         ic_flush;
    logic         mem_req;
    logic [14:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic [255:0] ic_fill_data;
    logic         ic_miss_ack;
    logic         ic_fill_busy;

    modport master (
        input  ic_miss,
        input  ic_miss_addr,
        input  ic_flush,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata,
        output mem_req,
        output mem_addr,
        output ic_fill_data,
        output ic_miss_ack,
        output ic_fill_busy
    );

    modport slave (
        output ic_miss,
        output ic_miss_addr,
        output ic_flush,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata,
        input  mem_req,
        input  mem_addr,
        input  ic_fill_data,
        input  ic_miss_ack,
        input  ic_fill_busy
    );
endinterface

// File: rtl/ic_fill_ctrl.sv
// Instruction-cache miss-fill sequencer: requests a 32 B line from the
// memory arbiter, assembles eight 32-bit beats and strobes the cache fill.
module ic_fill_ctrl #(
    parameter int BEATS = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    ic_fill_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, REQ, XFER, DRAIN, FILL, DONE
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [2:0]   cnt;
    logic [14:0]  addr_q;
    logic [255:0] line_q;
    logic         beat_vld;
    logic [31:0]  beat_data;
    logic         burst;
    logic         take;
    logic         last_beat;
    logic         unused_ok;

    assign burst     = (state == XFER) || (state == DRAIN);
    assign take      = beat_vld && burst;
    assign last_beat = take && (cnt == 3'(BEATS - 1));
    assign unused_ok = ^bus.ic_miss_addr[4:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.ic_miss && !bus.ic_flush) state_nxt = REQ;
            end
            REQ: begin
                // a grant commits the burst even when a flush lands with it
                if (bus.mem_gnt) state_nxt = bus.ic_flush ? DRAIN : XFER;
                else if (bus.ic_flush) state_nxt = IDLE;
            end
            XFER: begin
                if (last_beat) state_nxt = bus.ic_flush ? IDLE : FILL;
                else if (bus.ic_flush) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (last_beat) state_nxt = IDLE;
            end
            FILL:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req      = 1'b0;
        bus.ic_miss_ack  = 1'b0;
        bus.ic_fill_busy = 1'b1;
        unique case (state)
            IDLE:    bus.ic_fill_busy = 1'b0;
            REQ:     bus.mem_req = 1'b1;
            FILL:    bus.ic_miss_ack = 1'b1;
            default: ;
        endcase
    end

    // beats are staged one cycle before being merged into the line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_vld  <= 1'b0;
            beat_data <= '0;
        end else begin
            beat_vld  <= bus.mem_rvalid && burst;
            beat_data <= bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            line_q <= '0;
            cnt    <= '0;
        end else begin
            if (state == IDLE && state_nxt == REQ) begin
                addr_q <= {bus.ic_miss_addr[14:5], 5'b0};
                line_q <= '0;
            end
            if (state == REQ && bus.mem_gnt) begin
                cnt <= '0;
            end else if (take) begin
                cnt <= cnt + 3'd1;
            end
            if (take && state == XFER) begin
                line_q[{cnt, 5'b0} +: 32] <= beat_data;
            end
        end
    end

    assign bus.mem_addr     = addr_q;
    assign bus.ic_fill_data = line_q;
endmodule

// File: doc/ic_fill_ctrl.md
# ic_fill_ctrl

Miss-fill sequencer for the 512 B direct-mapped instruction cache (16 lines × 32 B). It watches the cache's miss indication, requests the missing line from the memory-bus arbiter, and assembles eight 32-bit read beats into a 256-bit fill line. It then pulses `ic_miss_ack` for exactly one cycle; the cache uses that pulse both as its write strobe (its write enable is active-low on `~ic_miss_ack`) and as its hit mask. The block sits between the fetch-stage cache and the shared memory arbiter.

## Interface
Parameters:
- `BEATS`, 8: beats per line. The design is fixed at 32 B / 32 bit; other values are unsupported.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ic_miss`  in  1  cache miss (already gated by `ren` and `~ic_exp`).
- `ic_miss_addr`  in  15  physical line address `{tag[5:0], index[3:0], 5'b0}`.
- `ic_flush`  in  1  fetch redirect or exception; abandons the current fill.
- `mem_req`  out  1  burst read request to the arbiter.
- `mem_addr`  out  15  line-aligned burst address; bits [4:0] are always 0.
- `mem_gnt`  in  1  arbiter grant, one-cycle pulse.
- `mem_rvalid`  in  1  read beat valid.
- `mem_rdata`  in  32  read beat data.
- `ic_fill_data`  out  256  assembled line, driven to the cache fill port.
- `ic_miss_ack`  out  1  one-cycle fill strobe.
- `ic_fill_busy`  out  1  high in every state except IDLE.

## Operation
States: IDLE, REQ, XFER, DRAIN, FILL, DONE.

- **IDLE**
  - On `ic_miss` with `~ic_flush`: latch `{ic_miss_addr[14:5], 5'b0}` into `mem_addr`, clear `ic_fill_data`, go to REQ.
  - `ic_miss` together with `ic_flush` is ignored.
- **REQ**
  - `mem_req` = 1.
  - On `mem_gnt`: beat count ← 0, go to XFER.
  - On `ic_flush` without `mem_gnt`: drop the request and go to IDLE.
  - If `ic_flush` and `mem_gnt` occur together, the grant wins (the burst is committed), and the flush is recorded so the FSM goes to DRAIN.
- **XFER**
  - `mem_req` = 0.
  - Each `mem_rvalid` writes `mem_rdata` into `ic_fill_data[32*cnt+31 : 32*cnt]` and increments the 3-bit `cnt`. Beat 0 is the lowest address (little-endian byte order within the line).
  - The beat with `cnt` = 7 completes the line → FILL.
  - `ic_flush` at any point → DRAIN. Beats already stored are kept, but the line will not be written.
- **DRAIN**
  - The bus burst cannot be aborted, so remaining beats are counted and discarded.
  - After the 8th beat → IDLE. No `ic_miss_ack` is issued.
- **FILL**
  - `ic_miss_ack` = 1 for exactly this one cycle, then → DONE.
  - `ic_flush` in FILL does not suppress the ack, because the line data is valid.
- **DONE**
  - One dead cycle that ignores `ic_miss`, so the stale miss (tag not yet visible) cannot re-trigger a fill. Then → IDLE.

General rules:
- `mem_rvalid` is ignored in IDLE, REQ, FILL and DONE.
- `mem_gnt` is ignored outside REQ.
- `ic_fill_data` holds its value from FILL until the next miss is accepted in IDLE.
- `cnt` wraps 7 → 0; it is only meaningful in XFER and DRAIN.

## Timing
- Reset (asynchronous, `rst_n` = 0): state = IDLE, `mem_req` = 0, `mem_addr` = 0, `ic_fill_data` = 0, `ic_miss_ack` = 0, `ic_fill_busy` = 0, `cnt` = 0. This applies even mid-burst; the arbiter is reset by the same `rst_n`.
- All outputs are registered.
  - Miss sampled at edge 0 → `mem_req` high after edge 0 (cycle 1).
  - Grant sampled at edge g → first beat can be accepted at edge g+1.
- Miss-to-ack latency with grant in cycle 1 and back-to-back beats: `ic_miss_ack` is high in cycle 11.
  - Edge 0: accept the miss.
  - Edge 1: grant sampled.
  - Edges 2–9: beats 0–7.
  - Edge 10: enter FILL, so ack is high in cycle 11.
- Next miss acceptance: ack cycle + 2 at the earliest (DONE in between).
- Gaps in `mem_rvalid` only stretch XFER; there is no timeout.

## Test plan
- **Basic fill.**
  - Stimulus: miss with `ic_miss_addr` = 15'h1A60, grant one cycle after `mem_req` rises, beats 32'h0000_0000..32'h0000_0007 back-to-back.
  - Required response: `mem_addr` = 15'h1A60; `ic_fill_data` = {32'h7, …, 32'h0}; `ic_miss_ack` high for exactly one cycle, 11 cycles after the miss; `ic_fill_busy` low 2 cycles after the ack.
- **Gapped beats.**
  - Stimulus: same as basic fill, with `mem_rvalid` toggling every other cycle and grant delayed 5 cycles.
  - Required response: identical data; ack at cycle 11 + 5 + 7.
- **Flush in REQ before grant.**
  - Required response: `mem_req` falls the next cycle, state is IDLE, no ack.
  - Then a new miss to 15'h0020 is accepted and fills normally.
- **Flush during XFER after 3 beats.**
  - Required response: the remaining 5 beats are consumed, no ack is issued, `ic_fill_busy` drops after the 8th beat.
  - A following miss starts with `ic_fill_data` cleared.
- **Corner events.**
  - Flush and grant in the same cycle → DRAIN, no ack.
  - Flush during FILL → ack still pulses.
  - `ic_miss` held high through DONE → no second request.
- **Async reset mid-burst after 4 beats.**
  - Required response: all outputs read 0 immediately, before the next edge.
  - After release, a new miss is accepted and the 8-beat fill completes correctly.
